// File: rtl/perf_counter_bank_if.sv
// CSR-style read/preset bus for perf_counter_bank.
// The master issues reads and presets; the slave (the counter bank) returns registered read data.
interface perf_counter_bank_if #(
  parameter int AW = 3
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_hi;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_hi;
  logic [31:0]   wr_data;

  modport master (
    output rd_en, rd_addr, rd_hi, wr_en, wr_addr, wr_hi, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, rd_hi, wr_en, wr_addr, wr_hi, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Performance-monitor bank: cycle, instret and NUM_EVT event counters with preset, sticky overflow and IRQ.
// Optional PERF_SNAPSHOT_EN adds a snap input and shadow registers for coherent 64-bit reads.
module perf_counter_bank #(
  parameter int NUM_EVT   = 4,
  parameter int CNT_W     = 64,
  parameter int EVT_INC_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         retire_valid,
  input  logic [NUM_EVT*EVT_INC_W-1:0] evt_inc,
  input  logic [NUM_EVT+1:0]           inhibit,
  input  logic                         freeze,
`ifdef PERF_SNAPSHOT_EN
  input  logic                         snap,
`endif
  output logic [NUM_EVT+1:0]           ovf,
  input  logic [NUM_EVT+1:0]           ovf_clr,
  input  logic [NUM_EVT+1:0]           ovf_irq_en,
  output logic                         ovf_irq,
  perf_counter_bank_if.slave           bus
);
  localparam int NCNT = NUM_EVT + 2;
  localparam int AW   = $clog2(NCNT);

  logic [CNT_W-1:0]     cnt_q [NCNT];
  logic [CNT_W-1:0]     cnt_d [NCNT];
  logic [CNT_W-1:0]     src   [NCNT];
  logic [EVT_INC_W-1:0] inc   [NCNT];
  logic [NCNT-1:0]      ovf_q, ovf_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 irq_q, irq_d;

  // Modulo-2^CNT_W add that keeps the carry out as the top bit.
  function automatic logic [CNT_W:0] wrap_add(input logic [CNT_W-1:0] a,
                                              input logic [EVT_INC_W-1:0] b);
    return {1'b0, a} + {{(CNT_W + 1 - EVT_INC_W){1'b0}}, b};
  endfunction

  function automatic logic [63:0] zext64(input logic [CNT_W-1:0] v);
    logic [63:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shad_q [NCNT];
  logic [CNT_W-1:0] shad_d [NCNT];

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      shad_d[i] = snap ? cnt_q[i] : shad_q[i];
      src[i]    = shad_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCNT; i++) begin
      if (rst) shad_q[i] <= '0;
      else     shad_q[i] <= shad_d[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NCNT; i++) src[i] = cnt_q[i];
  end
`endif

  always_comb begin
    logic [CNT_W:0] sum;
    sum    = '0;
    inc[0] = EVT_INC_W'(1);
    inc[1] = EVT_INC_W'(retire_valid);
    for (int e = 0; e < NUM_EVT; e++) inc[e+2] = evt_inc[e*EVT_INC_W +: EVT_INC_W];

    for (int i = 0; i < NCNT; i++) begin
      sum      = wrap_add(cnt_q[i], inc[i]);
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i] & ~ovf_clr[i];
      // A preset swallows this cycle's increment, so it can never raise overflow.
      if (bus.wr_en && bus.wr_addr == AW'(i)) begin
        if (bus.wr_hi) cnt_d[i][CNT_W-1:32] = bus.wr_data[CNT_W-33:0];
        else           cnt_d[i][31:0]       = bus.wr_data;
      end else if (!freeze && !inhibit[i]) begin
        cnt_d[i] = sum[CNT_W-1:0];
        if (sum[CNT_W]) ovf_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [63:0] rd_word;
    rd_word = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (bus.rd_addr == AW'(i)) rd_word = zext64(src[i]);
    end
    rd_data_d  = rd_data_q;
    if (bus.rd_en) rd_data_d = bus.rd_hi ? rd_word[63:32] : rd_word[31:0];
    rd_valid_d = bus.rd_en;
    irq_d      = |(ovf_q & ovf_irq_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign ovf          = ovf_q;
  assign ovf_irq      = irq_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule
